// File: rtl/wb_cmd_master.sv
// Wishbone classic single-cycle master: turns a host command plus write/read word
// streams into address-incrementing bus cycles, each bounded by an ack timeout.
module wb_cmd_master #(
  parameter int ADDR_STEP = 4,
  parameter int LEN_W     = 8,
  parameter int TIMEOUT   = 255
) (
  input  logic             clk,
  input  logic             nRST,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_write,
  input  logic [31:0]      cmd_addr,
  input  logic [LEN_W-1:0] cmd_len,
  input  logic             wdata_valid,
  output logic             wdata_ready,
  input  logic [31:0]      wdata,
  output logic             rdata_valid,
  input  logic             rdata_ready,
  output logic [31:0]      rdata,
  output logic [31:0]      wb_adr_o,
  output logic [31:0]      wb_dat_o,
  output logic [3:0]       wb_sel_o,
  output logic             wb_we_o,
  output logic             wb_cyc_o,
  output logic             wb_stb_o,
  input  logic             wb_ack_i,
  input  logic [31:0]      wb_dat_i,
  output logic             busy,
  output logic             done,
  output logic             timeout_err
);

  localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    BUS   = 2'd2,
    PUSH  = 2'd3
  } state_t;

  state_t             state_r;
  state_t             state_next_s;
  logic [31:0]        addr_r;
  logic [LEN_W-1:0]   rem_r;
  logic               dir_r;
  logic [CNT_W-1:0]   cnt_r;
  logic               cyc_r;
  logic               we_r;
  logic [3:0]         sel_r;
  logic [31:0]        dat_o_r;
  logic [31:0]        rdata_r;
  logic               rdata_valid_r;
  logic               done_r;
  logic               timeout_err_r;

  logic               cmd_fire_s;
  logic               wdata_fire_s;
  logic               rdata_fire_s;
  logic               last_s;
  logic               tmo_s;
  logic               dir_s;
  logic               bus_next_s;

  assign cmd_fire_s   = cmd_valid & (state_r == IDLE);
  assign wdata_fire_s = wdata_valid & (state_r == FETCH);
  assign rdata_fire_s = rdata_ready & (state_r == PUSH);
  assign last_s       = (rem_r == LEN_W'(1));
  // Abort on the TIMEOUT-th BUS cycle unless the slave acks in that same cycle.
  assign tmo_s        = (state_r == BUS) & ~wb_ack_i & (cnt_r == CNT_W'(TIMEOUT - 1));
  // Only reads enter BUS straight from IDLE, before dir_r has been loaded.
  assign dir_s        = (state_r == IDLE) ? cmd_write : dir_r;
  assign bus_next_s   = (state_next_s == BUS);

  // State register
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state decode
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (cmd_fire_s && (cmd_len != {LEN_W{1'b0}})) begin
          state_next_s = cmd_write ? FETCH : BUS;
        end else begin
          state_next_s = IDLE;
        end
      end
      FETCH: begin
        if (wdata_fire_s) begin
          state_next_s = BUS;
        end else begin
          state_next_s = FETCH;
        end
      end
      BUS: begin
        if (wb_ack_i) begin
          if (dir_r) begin
            state_next_s = last_s ? IDLE : FETCH;
          end else begin
            state_next_s = PUSH;
          end
        end else if (tmo_s) begin
          state_next_s = IDLE;
        end else begin
          state_next_s = BUS;
        end
      end
      PUSH: begin
        if (rdata_fire_s) begin
          state_next_s = last_s ? IDLE : BUS;
        end else begin
          state_next_s = PUSH;
        end
      end
      default: state_next_s = IDLE;
    endcase
  end

  // Handshake outputs decoded from state
  always_comb begin
    cmd_ready   = 1'b0;
    wdata_ready = 1'b0;
    busy        = 1'b0;
    case (state_r)
      IDLE:    cmd_ready   = 1'b1;
      FETCH:   begin wdata_ready = 1'b1; busy = 1'b1; end
      BUS:     busy        = 1'b1;
      PUSH:    busy        = 1'b1;
      default: busy        = 1'b0;
    endcase
  end

  // Datapath and registered bus/status outputs
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      addr_r        <= 32'h0;
      rem_r         <= {LEN_W{1'b0}};
      dir_r         <= 1'b0;
      cnt_r         <= {CNT_W{1'b0}};
      cyc_r         <= 1'b0;
      we_r          <= 1'b0;
      sel_r         <= 4'h0;
      dat_o_r       <= 32'h0;
      rdata_r       <= 32'h0;
      rdata_valid_r <= 1'b0;
      done_r        <= 1'b0;
      timeout_err_r <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (cmd_fire_s) begin
            addr_r        <= cmd_addr;
            rem_r         <= cmd_len;
            dir_r         <= cmd_write;
            timeout_err_r <= 1'b0;
            done_r        <= (cmd_len == {LEN_W{1'b0}});
          end
        end
        FETCH: begin
          if (wdata_fire_s) begin
            dat_o_r <= wdata;
          end
        end
        BUS: begin
          if (wb_ack_i) begin
            if (dir_r) begin
              if (last_s) begin
                done_r <= 1'b1;
              end else begin
                addr_r <= addr_r + 32'(ADDR_STEP);
                rem_r  <= rem_r - LEN_W'(1);
              end
            end else begin
              rdata_r       <= wb_dat_i;
              rdata_valid_r <= 1'b1;
            end
          end else if (tmo_s) begin
            timeout_err_r <= 1'b1;
            done_r        <= 1'b1;
          end
        end
        PUSH: begin
          if (rdata_fire_s) begin
            rdata_valid_r <= 1'b0;
            if (last_s) begin
              done_r <= 1'b1;
            end else begin
              addr_r <= addr_r + 32'(ADDR_STEP);
              rem_r  <= rem_r - LEN_W'(1);
            end
          end
        end
        default: done_r <= 1'b0;
      endcase

      // Bus qualifiers track the next state so cyc drops on the same edge done rises.
      cyc_r <= bus_next_s;
      we_r  <= bus_next_s & dir_s;
      sel_r <= {4{bus_next_s}};
      if (bus_next_s && (state_r != BUS)) begin
        cnt_r <= {CNT_W{1'b0}};
      end else if (state_r == BUS) begin
        cnt_r <= cnt_r + CNT_W'(1);
      end
    end
  end

  assign wb_adr_o    = addr_r;
  assign wb_dat_o    = dat_o_r;
  assign wb_sel_o    = sel_r;
  assign wb_we_o     = we_r;
  assign wb_cyc_o    = cyc_r;
  assign wb_stb_o    = cyc_r;
  assign rdata       = rdata_r;
  assign rdata_valid = rdata_valid_r;
  assign done        = done_r;
  assign timeout_err = timeout_err_r;

endmodule
